// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pkg
// Purpose  : Shared widths, stall encodings, ALU opcodes, divider state
//            encodings and the ID->EX bus layout for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 144;
  localparam int EX_TO_MEM_WD = 76;
  localparam int StallBus     = 6;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_MFHI = 4'd14;
  localparam logic [3:0] ALU_MFLO = 4'd15;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Field order matches the ID->EX bus, MSB first (144 bits total).
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] store_data;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
  } id_to_ex_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : 32-step restoring divider (signed or unsigned) with its own
//            IDLE/CALC/DONE sequencer and step counter.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start           - begin a divide (sampled in IDLE)
//            is_signed       - treat a/b as two's complement
//            a, b            - dividend, divisor
//            busy            - asserted in IDLE-with-start and in CALC
//            done            - asserted for the single DONE cycle
//            quo, rem        - sign-corrected results, valid while done
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  div_state_t  r_state, w_state_nxt;
  logic [4:0]  r_count;
  logic [31:0] r_divisor, r_quo, r_rem;
  logic        r_quo_neg, r_rem_neg, r_div_zero;

  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_shifted;
  logic        w_fits;

  assign w_a_mag = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag = (is_signed && b[31]) ? (32'd0 - b) : b;

  // Quotient bits shift out of r_quo's MSB into the partial remainder.
  assign w_shifted = {r_rem, r_quo[31]};
  assign w_fits    = (w_shifted >= {1'b0, r_divisor});

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (start) begin
          busy        = 1'b1;
          w_state_nxt = DIV_CALC;
        end
      end
      DIV_CALC: begin
        busy = 1'b1;
        if (r_count == 5'd31) w_state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        done        = 1'b1;
        w_state_nxt = DIV_IDLE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 5'd0;
      r_divisor  <= 32'd0;
      r_quo      <= 32'd0;
      r_rem      <= 32'd0;
      r_quo_neg  <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (r_state == DIV_IDLE) begin
      if (start) begin
        r_count    <= 5'd0;
        r_divisor  <= w_b_mag;
        r_quo      <= w_a_mag;
        r_rem      <= 32'd0;
        r_quo_neg  <= is_signed && (a[31] ^ b[31]);
        r_rem_neg  <= is_signed && a[31];
        r_div_zero <= (b == 32'd0);
      end
    end else if (r_state == DIV_CALC) begin
      r_count <= r_count + 5'd1;
      r_quo   <= {r_quo[30:0], w_fits};
      r_rem   <= w_fits ? (w_shifted[31:0] - r_divisor) : w_shifted[31:0];
    end
  end

  // A zero divisor naturally leaves |dividend| as remainder; only the
  // quotient needs forcing, since sign correction would otherwise flip it.
  assign quo = r_div_zero ? 32'hFFFF_FFFF : (r_quo_neg ? (32'd0 - r_quo) : r_quo);
  assign rem = r_rem_neg ? (32'd0 - r_rem) : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage: ID->EX pipe register, ALU, data SRAM request,
//            HI/LO registers and divider control with front-end stall.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            stall             - pipeline stall vector (bit2 EX, bit3 MEM)
//            id_to_ex_bus      - decoded instruction from ID
//            ex_to_mem_bus     - packed result for MEM
//            ex_to_rf_bus      - {rf_we, rf_waddr, ex_result} bypass to ID
//            data_sram_*       - data memory request
//            stallreq_for_ex   - divide in progress
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   r_id_to_ex;
  logic        r_div_done;
  logic [31:0] r_hi, r_lo;

  logic        w_bubble, w_load;
  logic        w_is_div, w_div_start, w_div_busy, w_div_done;
  logic [31:0] w_quo, w_rem, w_sum, w_ex_result;
  logic [4:0]  w_shamt;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5:4], stall[1:0]};

  assign w_bubble = (stall[2] == Stop) && (stall[3] == NoStop);
  assign w_load   = w_bubble || (stall[2] == NoStop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_id_to_ex <= '0;
    else if (w_bubble)           r_id_to_ex <= '0;
    else if (stall[2] == NoStop) r_id_to_ex <= id_to_ex_bus;
  end

  // Remembers that the divide now sitting in the pipe register has already
  // finished, so a stall held by another source cannot restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_div_done <= 1'b0;
    else if (w_load)     r_div_done <= 1'b0;
    else if (w_div_done) r_div_done <= 1'b1;
  end

  assign w_is_div    = (r_id_to_ex.alu_op == ALU_DIV) || (r_id_to_ex.alu_op == ALU_DIVU);
  assign w_div_start = w_is_div && !r_div_done;

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .is_signed (r_id_to_ex.alu_op == ALU_DIV),
    .a         (r_id_to_ex.src_a),
    .b         (r_id_to_ex.src_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quo       (w_quo),
    .rem       (w_rem)
  );

  // HI/LO land on the DONE->IDLE edge, the same edge that loads the next
  // instruction, so an immediately following MFHI/MFLO sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_div_done) begin
      r_hi <= w_rem;
      r_lo <= w_quo;
    end
  end

  assign w_sum   = r_id_to_ex.src_a + r_id_to_ex.src_b;
  assign w_shamt = r_id_to_ex.src_a[4:0];

  always_comb begin
    w_ex_result = 32'd0;
    case (r_id_to_ex.alu_op)
      ALU_ADD:  w_ex_result = w_sum;
      ALU_SUB:  w_ex_result = r_id_to_ex.src_a - r_id_to_ex.src_b;
      ALU_AND:  w_ex_result = r_id_to_ex.src_a & r_id_to_ex.src_b;
      ALU_OR:   w_ex_result = r_id_to_ex.src_a | r_id_to_ex.src_b;
      ALU_XOR:  w_ex_result = r_id_to_ex.src_a ^ r_id_to_ex.src_b;
      ALU_NOR:  w_ex_result = ~(r_id_to_ex.src_a | r_id_to_ex.src_b);
      ALU_SLL:  w_ex_result = r_id_to_ex.src_b << w_shamt;
      ALU_SRL:  w_ex_result = r_id_to_ex.src_b >> w_shamt;
      ALU_SRA:  w_ex_result = $unsigned($signed(r_id_to_ex.src_b) >>> w_shamt);
      ALU_SLT:  w_ex_result = {31'd0, $signed(r_id_to_ex.src_a) < $signed(r_id_to_ex.src_b)};
      ALU_SLTU: w_ex_result = {31'd0, r_id_to_ex.src_a < r_id_to_ex.src_b};
      ALU_LUI:  w_ex_result = {r_id_to_ex.src_b[15:0], 16'd0};
      ALU_MFHI: w_ex_result = r_hi;
      ALU_MFLO: w_ex_result = r_lo;
      default:  w_ex_result = 32'd0;
    endcase
  end

  assign data_sram_en    = r_id_to_ex.mem_en;
  assign data_sram_wen   = r_id_to_ex.mem_wen;
  assign data_sram_addr  = w_sum;
  assign data_sram_wdata = r_id_to_ex.store_data;

  assign stallreq_for_ex = w_div_busy;

  assign ex_to_mem_bus = {r_id_to_ex.pc, r_id_to_ex.mem_en, r_id_to_ex.mem_wen,
                          r_id_to_ex.sel_rf_res, r_id_to_ex.rf_we,
                          r_id_to_ex.rf_waddr, w_ex_result};
  assign ex_to_rf_bus  = {r_id_to_ex.rf_we, r_id_to_ex.rf_waddr, w_ex_result};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage with a behavioural reference
//            model of the ALU, the HI/LO divide results and the stall rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [143:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] make_bus(input logic [31:0] pc, input logic [3:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic men, input logic [3:0] wen,
                                            input logic [31:0] sd, input logic sel,
                                            input logic we, input logic [4:0] waddr);
    return {pc, op, a, b, men, wen, sd, sel, we, waddr};
  endfunction

  // Reference ALU written from the instruction meanings, using 64-bit math.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ua, ub, sa, sb, sh, t;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    sh = longint'(a[4:0]);
    case (op)
      4'd0:  t = ua + ub;
      4'd1:  t = ua - ub;
      4'd2:  t = ua & ub;
      4'd3:  t = ua | ub;
      4'd4:  t = ua ^ ub;
      4'd5:  t = ~(ua | ub);
      4'd6:  t = ub * (longint'(1) << sh);
      4'd7:  t = ub / (longint'(1) << sh);
      4'd8:  t = (sb >= 0) ? (sb / (longint'(1) << sh))
                           : -((-sb + (longint'(1) << sh) - 1) / (longint'(1) << sh));
      4'd9:  t = (sa < sb) ? 1 : 0;
      4'd10: t = (ua < ub) ? 1 : 0;
      4'd11: t = (ub % 65536) * 65536;
      4'd14: t = longint'(m_hi);
      4'd15: t = longint'(m_lo);
      default: t = 0;
    endcase
    return t[31:0];
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint da, db, q, r;
    da = sgn ? longint'(signed'(a)) : longint'(a);
    db = sgn ? longint'(signed'(b)) : longint'(b);
    if (db == 0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else begin
      q = da / db;
      r = da % db;
      m_lo = q[31:0];
      m_hi = r[31:0];
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] pc, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic men,
                       input logic [3:0] wen, input logic [31:0] sd, input logic sel,
                       input logic we, input logic [4:0] waddr);
    logic [31:0] res;
    stall = 6'b000000;
    id_to_ex_bus = make_bus(pc, op, a, b, men, wen, sd, sel, we, waddr);
    tick();
    res = ref_alu(op, a, b);
    check({tag, "_mem_bus"}, ex_to_mem_bus, {pc, men, wen, sel, we, waddr, res});
    check({tag, "_rf_bus"}, 76'(ex_to_rf_bus), 76'({we, waddr, res}));
    check({tag, "_sram"}, 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          76'({men, wen, a + b, sd}));
  endtask

  // Acts as the stall controller: holds EX while stallreq is high.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic hold_after);
    int cnt;
    logic [31:0] pc;
    pc = $urandom;
    stall = 6'b000000;
    id_to_ex_bus = make_bus(pc, sgn ? 4'd12 : 4'd13, a, b, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    cnt = 0;
    while (stallreq_for_ex && cnt < 100) begin
      stall = 6'b001111;
      id_to_ex_bus = $urandom;
      tick();
      cnt++;
    end
    check({tag, "_stall_cycles"}, 76'(cnt), 76'd33);
    check({tag, "_div_result"}, ex_to_mem_bus, {pc, 44'd0});
    ref_div(sgn, a, b);
    if (hold_after) begin
      stall = 6'b001111;
      tick();
      tick();
      check({tag, "_no_restart"}, 76'(stallreq_for_ex), 76'd0);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    rst = 1'b1;
    stall = 6'b000000;
    id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    check("reset_mem_bus", ex_to_mem_bus, 76'd0);
    check("reset_rf_bus", 76'(ex_to_rf_bus), 76'd0);
    check("reset_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
    check("reset_stallreq", 76'(stallreq_for_ex), 76'd0);
    rst = 1'b0;

    issue("add", 32'h0040_0000, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd3);
    check("add_rf_const", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'd12}));

    issue("sw", 32'h0040_0004, 4'd0, 32'h1000, 32'd4, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
    check("sw_addr_const", 76'(data_sram_addr), 76'h1004);

    // Bubble: EX stalled, MEM running.
    stall = 6'b000111;
    id_to_ex_bus = make_bus(32'h1234, 4'd3, 32'hF0, 32'h0F, 1'b1, 4'h3, 32'h55, 1'b1, 1'b1, 5'd9);
    tick();
    check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    check("bubble_sram_en", 76'(data_sram_en), 76'd0);

    // Hold: EX and MEM both stalled.
    issue("pre_hold", 32'h0040_0010, 4'd4, 32'hA5A5_0000, 32'h0F0F_FFFF, 1'b1, 4'h0, 32'h77, 1'b1, 1'b1, 5'd17);
    stall = 6'b001111;
    id_to_ex_bus = make_bus(32'h9999, 4'd1, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd1);
    tick();
    check("hold_mem_bus", ex_to_mem_bus,
          {32'h0040_0010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd17, 32'hA5A5_0000 ^ 32'h0F0F_FFFF});

    // Random non-divide instructions.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd12) op = op + 4'd2;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a[31] = ~b[31];
      issue("rand", $urandom, op, a, b, 1'($urandom), 4'($urandom), $urandom,
            1'($urandom), 1'($urandom), 5'($urandom));
    end

    // DIV -7 / 2 followed by MFLO and MFHI.
    run_div("div_m7", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue("mflo_m7", 32'h100, 4'd15, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd2);
    check("mflo_m7_const", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFD);
    issue("mfhi_m7", 32'h104, 4'd14, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd4);
    check("mfhi_m7_const", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFF);

    // DIVU by zero, with an external stall holding EX past DONE.
    run_div("divu_z", 1'b0, 32'h8000_0000, 32'd0, 1'b1);
    issue("mflo_z", 32'h108, 4'd15, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd5);
    check("mflo_z_const", 76'(ex_to_rf_bus[31:0]), 76'hFFFF_FFFF);
    issue("mfhi_z", 32'h10C, 4'd14, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd6);
    check("mfhi_z_const", 76'(ex_to_rf_bus[31:0]), 76'h8000_0000);

    // Random divides.
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_div("div_rand", 1'(i % 2), a, b, 1'b0);
      issue("mflo_rand", $urandom, 4'd15, $urandom, $urandom, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd7);
      issue("mfhi_rand", $urandom, 4'd14, $urandom, $urandom, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd8);
    end

    // Make HI/LO non-zero, then reset in the middle of a divide (CALC count 10).
    run_div("div_pre_rst", 1'b0, 32'd1000, 32'd3, 1'b0);
    stall = 6'b000000;
    id_to_ex_bus = make_bus(32'h200, 4'd12, 32'd12345, 32'd67, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    tick();
    stall = 6'b001111;
    tick();
    repeat (10) tick();
    check("pre_rst_stallreq", 76'(stallreq_for_ex), 76'd1);
    rst = 1'b1;
    #1;
    check("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
    check("rst_mem_bus", ex_to_mem_bus, 76'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    stall = 6'b000000;
    tick();
    rst = 1'b0;
    issue("mflo_rst", 32'h300, 4'd15, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd9);
    issue("mfhi_rst", 32'h304, 4'd14, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd10);

    run_div("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0);
    issue("mflo_100_7", 32'h308, 4'd15, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd11);
    check("mflo_100_7_const", 76'(ex_to_rf_bus[31:0]), 76'd14);
    issue("mfhi_100_7", 32'h30C, 4'd14, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 5'd12);
    check("mfhi_100_7_const", 76'(ex_to_rf_bus[31:0]), 76'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
